// File: rtl/sim_memory_lsu_pkg.sv
// Shared definitions for the load/store adapter in front of sim_memory_model:
// order codes, read-tag layout, lane mask/shift and read-extract helpers.
package sim_memory_lsu_pkg;

    localparam logic [1:0] ORDER_BYTE  = 2'h0;
    localparam logic [1:0] ORDER_HWORD = 2'h1;
    localparam logic [1:0] ORDER_WORD  = 2'h2;
    localparam logic [1:0] ORDER_NONE  = 2'h3;

    localparam int TAG_W = 6;

    typedef struct packed {
        logic [2:0] addr;
        logic [1:0] order;
        logic       sgn;
    } tag_t;

    function automatic logic is_aligned(input logic [1:0] order, input logic [1:0] k);
        case (order)
            ORDER_BYTE:  is_aligned = 1'b1;
            ORDER_HWORD: is_aligned = (k[0] == 1'b0);
            ORDER_WORD:  is_aligned = (k == 2'b00);
            default:     is_aligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] order, input logic [1:0] k);
        case (order)
            ORDER_BYTE:  lane_mask = 4'b0001 << k;
            ORDER_HWORD: lane_mask = 4'b0011 << k;
            ORDER_WORD:  lane_mask = 4'b1111;
            default:     lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] order, input logic [1:0] k,
                                               input logic [31:0] data);
        case (order)
            ORDER_BYTE:  lane_wdata = {24'h0, data[7:0]} << {k, 3'b000};
            ORDER_HWORD: lane_wdata = {16'h0, data[15:0]} << {k, 3'b000};
            ORDER_WORD:  lane_wdata = data;
            default:     lane_wdata = 32'h0;
        endcase
    endfunction

    // Picks the 32-bit half by addr[2], then right-justifies the addressed bytes.
    function automatic logic [31:0] extract(input logic [63:0] line, input tag_t tag);
        logic [31:0] lane;
        logic [31:0] sh;
        lane = tag.addr[2] ? line[63:32] : line[31:0];
        sh   = lane >> {tag.addr[1:0], 3'b000};
        case (tag.order)
            ORDER_BYTE:  extract = {{24{tag.sgn & sh[7]}}, sh[7:0]};
            ORDER_HWORD: extract = {{16{tag.sgn & sh[15]}}, sh[15:0]};
            default:     extract = sh;
        endcase
    endfunction

endpackage

// File: rtl/sim_memory_tag_fifo.sv
// Synchronous FIFO holding the tags of outstanding reads; push and pop may
// happen in the same cycle.
module sim_memory_tag_fifo
    import sim_memory_lsu_pkg::*;
#(
    parameter int P_DEPTH   = 8,
    parameter int P_DEPTH_N = 3
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iPUSH,
    input  logic [TAG_W-1:0]     iDATA,
    input  logic                 iPOP,
    output logic [TAG_W-1:0]     oDATA,
    output logic                 oFULL,
    output logic                 oEMPTY,
    output logic [P_DEPTH_N:0]   oCOUNT
);

    localparam logic [P_DEPTH_N:0] LP_FULL = (P_DEPTH_N+1)'(P_DEPTH);

    logic [TAG_W-1:0]     r_mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] r_wr_ptr;
    logic [P_DEPTH_N-1:0] r_rd_ptr;
    logic [P_DEPTH_N:0]   r_count;

    always_ff @(posedge iCLOCK) begin
        if (iPUSH) begin
            r_mem[r_wr_ptr] <= iDATA;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (iPUSH) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (iPOP)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({iPUSH, iPOP})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign oDATA  = r_mem[r_rd_ptr];
    assign oFULL  = (r_count == LP_FULL);
    assign oEMPTY = (r_count == '0);
    assign oCOUNT = r_count;

endmodule

// File: rtl/sim_memory_lsu_adapter.sv
// Load/store adapter: lane-shifts requests into sim_memory_model and extracts,
// extends and registers returned read data in issue order.
module sim_memory_lsu_adapter
    import sim_memory_lsu_pkg::*;
#(
    parameter int P_TAG_DEPTH   = 8,
    parameter int P_TAG_DEPTH_N = 3
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iREQ_VALID,
    output logic        oREQ_LOCK,
    input  logic [1:0]  iREQ_ORDER,
    input  logic        iREQ_RW,
    input  logic        iREQ_SIGNED,
    input  logic [25:0] iREQ_ADDR,
    input  logic [31:0] iREQ_DATA,
    output logic        oREQ_ERR,
    output logic        oMEMORY_REQ,
    input  logic        iMEMORY_LOCK,
    output logic [1:0]  oMEMORY_ORDER,
    output logic [3:0]  oMEMORY_MASK,
    output logic        oMEMORY_RW,
    output logic [25:0] oMEMORY_ADDR,
    output logic [31:0] oMEMORY_DATA,
    input  logic        iMEMORY_VALID,
    output logic        oMEMORY_LOCK,
    input  logic [63:0] iMEMORY_DATA,
    output logic        oRD_VALID,
    input  logic        iRD_LOCK,
    output logic [31:0] oRD_DATA,
    output logic        oPROTO_ERR
);

    localparam logic [P_TAG_DEPTH_N:0] LP_TAG_MAX = (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);

    // Handshake: a transfer happens on any cycle where valid=1 and lock=0; a
    // producer facing lock=1 keeps its request steady and retries next cycle.
    logic                   w_accept;
    logic                   w_aligned;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_tag_full;
    logic                   w_tag_empty;
    logic [P_TAG_DEPTH_N:0] w_tag_count;
    tag_t                   w_push_tag;
    tag_t                   w_head_tag;

    logic                   r_req_err;
    logic                   r_proto_err;
    logic                   r_rd_valid;
    logic [31:0]            r_rd_data;

    assign oREQ_LOCK   = iMEMORY_LOCK || w_tag_full;
    assign w_accept    = iREQ_VALID && !oREQ_LOCK;
    assign w_aligned   = is_aligned(iREQ_ORDER, iREQ_ADDR[1:0]);
    assign oMEMORY_REQ = w_accept && w_aligned;

    assign oMEMORY_ORDER = iREQ_ORDER;
    assign oMEMORY_RW    = iREQ_RW;
    assign oMEMORY_ADDR  = iREQ_ADDR;
    assign oMEMORY_MASK  = lane_mask(iREQ_ORDER, iREQ_ADDR[1:0]);
    assign oMEMORY_DATA  = lane_wdata(iREQ_ORDER, iREQ_ADDR[1:0], iREQ_DATA);

    assign w_push_tag = '{addr: iREQ_ADDR[2:0], order: iREQ_ORDER, sgn: iREQ_SIGNED};
    assign w_push     = oMEMORY_REQ && !iREQ_RW;
    // A response with no tag outstanding is a protocol error and is discarded.
    assign w_pop      = iMEMORY_VALID && !w_tag_empty;

    sim_memory_tag_fifo #(
        .P_DEPTH   (P_TAG_DEPTH),
        .P_DEPTH_N (P_TAG_DEPTH_N)
    ) u_tag_fifo (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .iPUSH  (w_push),
        .iDATA  (w_push_tag),
        .iPOP   (w_pop),
        .oDATA  (w_head_tag),
        .oFULL  (w_tag_full),
        .oEMPTY (w_tag_empty),
        .oCOUNT (w_tag_count)
    );

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_req_err   <= 1'b0;
            r_proto_err <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 32'h0;
        end else begin
            r_req_err   <= w_accept && !w_aligned;
            r_proto_err <= r_proto_err || (iMEMORY_VALID && w_tag_empty);
            if (w_pop) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= extract(iMEMORY_DATA, w_head_tag);
            end else if (!iRD_LOCK) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign oREQ_ERR     = r_req_err;
    assign oPROTO_ERR   = r_proto_err;
    assign oRD_VALID    = r_rd_valid;
    assign oRD_DATA     = r_rd_data;
    assign oMEMORY_LOCK = r_rd_valid && iRD_LOCK;

    tag_count_bound: assert property (@(posedge iCLOCK) disable iff (iRESET)
        w_tag_count <= LP_TAG_MAX);

endmodule

// File: tb/tb_sim_memory_lsu_adapter.sv
// Directed bench for sim_memory_lsu_adapter: request/read vector tables plus
// sequences for tag-FIFO fill, output hold and empty-FIFO responses.
module tb_sim_memory_lsu_adapter;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iREQ_VALID;
    logic        oREQ_LOCK;
    logic [1:0]  iREQ_ORDER;
    logic        iREQ_RW;
    logic        iREQ_SIGNED;
    logic [25:0] iREQ_ADDR;
    logic [31:0] iREQ_DATA;
    logic        oREQ_ERR;
    logic        oMEMORY_REQ;
    logic        iMEMORY_LOCK;
    logic [1:0]  oMEMORY_ORDER;
    logic [3:0]  oMEMORY_MASK;
    logic        oMEMORY_RW;
    logic [25:0] oMEMORY_ADDR;
    logic [31:0] oMEMORY_DATA;
    logic        iMEMORY_VALID;
    logic        oMEMORY_LOCK;
    logic [63:0] iMEMORY_DATA;
    logic        oRD_VALID;
    logic        iRD_LOCK;
    logic [31:0] oRD_DATA;
    logic        oPROTO_ERR;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] LINE = 64'h89ABCDEF_01234567;

    sim_memory_lsu_adapter #(.P_TAG_DEPTH(8), .P_TAG_DEPTH_N(3)) dut (
        .iCLOCK        (iCLOCK),
        .iRESET        (iRESET),
        .iREQ_VALID    (iREQ_VALID),
        .oREQ_LOCK     (oREQ_LOCK),
        .iREQ_ORDER    (iREQ_ORDER),
        .iREQ_RW       (iREQ_RW),
        .iREQ_SIGNED   (iREQ_SIGNED),
        .iREQ_ADDR     (iREQ_ADDR),
        .iREQ_DATA     (iREQ_DATA),
        .oREQ_ERR      (oREQ_ERR),
        .oMEMORY_REQ   (oMEMORY_REQ),
        .iMEMORY_LOCK  (iMEMORY_LOCK),
        .oMEMORY_ORDER (oMEMORY_ORDER),
        .oMEMORY_MASK  (oMEMORY_MASK),
        .oMEMORY_RW    (oMEMORY_RW),
        .oMEMORY_ADDR  (oMEMORY_ADDR),
        .oMEMORY_DATA  (oMEMORY_DATA),
        .iMEMORY_VALID (iMEMORY_VALID),
        .oMEMORY_LOCK  (oMEMORY_LOCK),
        .iMEMORY_DATA  (iMEMORY_DATA),
        .oRD_VALID     (oRD_VALID),
        .iRD_LOCK      (iRD_LOCK),
        .oRD_DATA      (oRD_DATA),
        .oPROTO_ERR    (oPROTO_ERR)
    );

    // Clock / watchdog
    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle();
        iREQ_VALID    = 1'b0;
        iREQ_ORDER    = 2'h0;
        iREQ_RW       = 1'b0;
        iREQ_SIGNED   = 1'b0;
        iREQ_ADDR     = 26'h0;
        iREQ_DATA     = 32'h0;
        iMEMORY_LOCK  = 1'b0;
        iMEMORY_VALID = 1'b0;
        iMEMORY_DATA  = 64'h0;
        iRD_LOCK      = 1'b0;
    endtask

    task automatic do_reset();
        iRESET = 1'b1;
        step();
        step();
        iRESET = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] order, input logic rw, input logic sgn,
                             input logic [25:0] addr, input logic [31:0] data);
        iREQ_VALID  = 1'b1;
        iREQ_ORDER  = order;
        iREQ_RW     = rw;
        iREQ_SIGNED = sgn;
        iREQ_ADDR   = addr;
        iREQ_DATA   = data;
    endtask

    task automatic respond(input logic [63:0] line);
        iMEMORY_VALID = 1'b1;
        iMEMORY_DATA  = line;
    endtask

    // Scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  order;
        logic        rw;
        logic [25:0] addr;
        logic [31:0] data;
        logic        exp_req;
        logic [3:0]  exp_mask;
        logic [31:0] exp_mdata;
        logic        exp_err;
    } req_vec_t;

    typedef struct {
        logic [1:0]  order;
        logic        sgn;
        logic [25:0] addr;
        logic [31:0] exp_rd;
    } rd_vec_t;

    req_vec_t req_tab[7];
    rd_vec_t  rd_tab[9];
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    initial begin
        req_tab[0] = '{2'h0, 1'b1, 26'h22, 32'h000000AB, 1'b1, 4'b0100, 32'h00AB0000, 1'b0};
        req_tab[1] = '{2'h2, 1'b0, 26'h21, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1};
        req_tab[2] = '{2'h1, 1'b0, 26'h13, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1};
        req_tab[3] = '{2'h1, 1'b1, 26'h06, 32'h1234BEEF, 1'b1, 4'b1100, 32'hBEEF0000, 1'b0};
        req_tab[4] = '{2'h2, 1'b1, 26'h08, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0};
        req_tab[5] = '{2'h3, 1'b1, 26'h00, 32'h12345678, 1'b0, 4'b0000, 32'h0,        1'b1};
        req_tab[6] = '{2'h0, 1'b1, 26'h03, 32'h0000005A, 1'b1, 4'b1000, 32'h5A000000, 1'b0};

        rd_tab[0] = '{2'h0, 1'b0, 26'h11, 32'h00000045};
        rd_tab[1] = '{2'h0, 1'b1, 26'h17, 32'hFFFFFF89};
        rd_tab[2] = '{2'h1, 1'b0, 26'h16, 32'h000089AB};
        rd_tab[3] = '{2'h1, 1'b1, 26'h12, 32'h00000123};
        rd_tab[4] = '{2'h1, 1'b1, 26'h14, 32'hFFFFCDEF};
        rd_tab[5] = '{2'h2, 1'b0, 26'h10, 32'h01234567};
        rd_tab[6] = '{2'h2, 1'b1, 26'h14, 32'h89ABCDEF};
        rd_tab[7] = '{2'h0, 1'b0, 26'h14, 32'h000000EF};
        rd_tab[8] = '{2'h0, 1'b1, 26'h10, 32'h00000067};

        idle();
        do_reset();

        check("rst_rd_valid", 32'(oRD_VALID), 32'h0);
        check("rst_rd_data", oRD_DATA, 32'h0);
        check("rst_req_err", 32'(oREQ_ERR), 32'h0);
        check("rst_proto_err", 32'(oPROTO_ERR), 32'h0);
        check("rst_req_lock", 32'(oREQ_LOCK), 32'h0);
        check("rst_count", 32'(dut.u_tag_fifo.oCOUNT), 32'h0);

        // Request-side table: writes and dropped requests push no tag.
        foreach (req_tab[i]) begin
            idle();
            drive_req(req_tab[i].order, req_tab[i].rw, 1'b0, req_tab[i].addr, req_tab[i].data);
            #1;
            check($sformatf("req%0d_memreq", i), 32'(oMEMORY_REQ), 32'(req_tab[i].exp_req));
            check($sformatf("req%0d_addr", i), 32'(oMEMORY_ADDR), 32'(req_tab[i].addr));
            if (req_tab[i].exp_req) begin
                check($sformatf("req%0d_mask", i), 32'(oMEMORY_MASK), 32'(req_tab[i].exp_mask));
                check($sformatf("req%0d_mdata", i), oMEMORY_DATA, req_tab[i].exp_mdata);
            end
            step();
            idle();
            check($sformatf("req%0d_err", i), 32'(oREQ_ERR), 32'(req_tab[i].exp_err));
            check($sformatf("req%0d_count", i), 32'(dut.u_tag_fifo.oCOUNT), 32'h0);
            step();
            check($sformatf("req%0d_err_clr", i), 32'(oREQ_ERR), 32'h0);
        end

        // Read table: one read, one returned line, one registered result.
        foreach (rd_tab[i]) begin
            idle();
            drive_req(rd_tab[i].order, 1'b0, rd_tab[i].sgn, rd_tab[i].addr, 32'h0);
            #1;
            check($sformatf("rd%0d_memreq", i), 32'(oMEMORY_REQ), 32'h1);
            step();
            idle();
            check($sformatf("rd%0d_count", i), 32'(dut.u_tag_fifo.oCOUNT), 32'h1);
            respond(LINE);
            step();
            idle();
            check($sformatf("rd%0d_valid", i), 32'(oRD_VALID), 32'h1);
            check($sformatf("rd%0d_data", i), oRD_DATA, rd_tab[i].exp_rd);
            step();
            check($sformatf("rd%0d_valid_clr", i), 32'(oRD_VALID), 32'h0);
        end

        // Fill the tag FIFO with 8 byte reads, then drain in issue order.
        exp_q = '{32'h67, 32'h45, 32'h23, 32'h01, 32'hEF, 32'hCD, 32'hAB, 32'h89};
        for (int i = 0; i < 8; i++) begin
            idle();
            drive_req(2'h0, 1'b0, 1'b0, 26'h10 + 26'(i), 32'h0);
            #1;
            check($sformatf("fill%0d_lock", i), 32'(oREQ_LOCK), 32'h0);
            step();
        end
        idle();
        drive_req(2'h0, 1'b0, 1'b0, 26'h18, 32'h0);
        respond(LINE);
        #1;
        check("full_lock", 32'(oREQ_LOCK), 32'h1);
        check("full_no_memreq", 32'(oMEMORY_REQ), 32'h0);
        step();
        idle();
        check("full_lock_drop", 32'(oREQ_LOCK), 32'h0);
        check("full_count7", 32'(dut.u_tag_fifo.oCOUNT), 32'h7);
        exp_v = exp_q.pop_front();
        check("drain0_valid", 32'(oRD_VALID), 32'h1);
        check("drain0_data", oRD_DATA, exp_v);
        for (int j = 1; j < 8; j++) begin
            respond(LINE);
            step();
            idle();
            exp_v = exp_q.pop_front();
            check($sformatf("drain%0d_valid", j), 32'(oRD_VALID), 32'h1);
            check($sformatf("drain%0d_data", j), oRD_DATA, exp_v);
        end
        step();
        check("drain_valid_clr", 32'(oRD_VALID), 32'h0);
        check("drain_count0", 32'(dut.u_tag_fifo.oCOUNT), 32'h0);

        // Output hold under iRD_LOCK, then back-to-back after release.
        idle();
        drive_req(2'h1, 1'b0, 1'b1, 26'h16, 32'h0);
        step();
        idle();
        drive_req(2'h0, 1'b0, 1'b0, 26'h11, 32'h0);
        step();
        idle();
        respond(LINE);
        step();
        idle();
        iRD_LOCK = 1'b1;
        #1;
        check("hold_memlock", 32'(oMEMORY_LOCK), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold%0d_valid", k), 32'(oRD_VALID), 32'h1);
            check($sformatf("hold%0d_data", k), oRD_DATA, 32'hFFFF89AB);
        end
        iRD_LOCK = 1'b0;
        #1;
        check("release_memlock", 32'(oMEMORY_LOCK), 32'h0);
        respond(LINE);
        step();
        idle();
        check("release_valid", 32'(oRD_VALID), 32'h1);
        check("release_data", oRD_DATA, 32'h00000045);
        step();
        check("release_valid_clr", 32'(oRD_VALID), 32'h0);

        // Reset with a read outstanding; the late response hits an empty FIFO.
        idle();
        drive_req(2'h2, 1'b0, 1'b0, 26'h10, 32'h0);
        step();
        idle();
        check("pre_rst_count", 32'(dut.u_tag_fifo.oCOUNT), 32'h1);
        do_reset();
        check("mid_rst_count", 32'(dut.u_tag_fifo.oCOUNT), 32'h0);
        check("mid_rst_proto", 32'(oPROTO_ERR), 32'h0);
        respond(LINE);
        step();
        idle();
        check("proto_set", 32'(oPROTO_ERR), 32'h1);
        check("proto_no_valid", 32'(oRD_VALID), 32'h0);
        step();
        step();
        check("proto_sticky", 32'(oPROTO_ERR), 32'h1);
        check("proto_still_no_valid", 32'(oRD_VALID), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
